// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
//   Shared types and constants for the RC4 phase sequencer.
//   - rc4_seq_state_t : sequencer FSM states (ST_ERR only when
//                       RC4_PHASE_TIMEOUT_EN is defined)
//   - rc4_owner_t     : which phase engine currently owns the S RAM port
//   - PHASE_*         : encoding of the 2-bit phase status output
//   - owner_of()      : owner implied by a given sequencer state
// Optional feature macro: RC4_PHASE_TIMEOUT_EN
// ---------------------------------------------------------------------------
package rc4_pkg;

  localparam logic [1:0] PHASE_IDLE = 2'd0;
  localparam logic [1:0] PHASE_INIT = 2'd1;
  localparam logic [1:0] PHASE_KSA  = 2'd2;
  localparam logic [1:0] PHASE_PRGA = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_KSA_GO,
    ST_KSA_RUN,
    ST_PRGA_GO,
    ST_PRGA_RUN,
    ST_DONE
`ifdef RC4_PHASE_TIMEOUT_EN
    , ST_ERR
`endif
  } rc4_seq_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_INIT,
    OWNER_KSA,
    OWNER_PRGA
  } rc4_owner_t;

  // Ownership is granted on entry to a GO state and held through RUN;
  // every other state leaves the RAM port undriven (owner none).
  function automatic rc4_owner_t owner_of(input rc4_seq_state_t st);
    rc4_owner_t own;
    own = OWNER_NONE;
    case (st)
      ST_INIT_GO, ST_INIT_RUN: own = OWNER_INIT;
      ST_KSA_GO,  ST_KSA_RUN:  own = OWNER_KSA;
      ST_PRGA_GO, ST_PRGA_RUN: own = OWNER_PRGA;
      default:                 own = OWNER_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/rc4_phase_watchdog.sv
// ---------------------------------------------------------------------------
// rc4_phase_watchdog
//   Per-phase cycle counter with expiry compare. Used by the sequencer only
//   when RC4_PHASE_TIMEOUT_EN is defined.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_clear    clear counter (sequencer in a GO state)
//   i_run      count enable (sequencer in a RUN state)
//   o_expired  high in the RUN cycle where the count has reached
//              TIMEOUT_CYC-1; the sequencer moves to ERR on the next edge
// ---------------------------------------------------------------------------
module rc4_phase_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_count;

  // Saturates at LIMIT so a caller that ignores o_expired never wraps.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_run && (r_count == LIMIT);

endmodule

// File: rtl/rc4_phase_sequencer.sv
// ---------------------------------------------------------------------------
// rc4_phase_sequencer
//   Runs the RC4 phases INIT -> KSA -> PRGA in order, issues a one-cycle
//   start pulse to each engine, waits for its finish, and multiplexes the
//   owning engine's address/data/write-enable onto the single S RAM port.
// Optional feature macro: RC4_PHASE_TIMEOUT_EN (per-phase watchdog + ERR).
// Ports:
//   i_clk, i_reset_n                       clock / async active-low reset
//   i_start                                begin a run (IDLE/DONE/ERR only)
//   o_init_start/o_ksa_start/o_prga_start  one-cycle phase start pulses
//   i_init_finish/i_ksa_finish/i_prga_finish  engine finished
//   i_<eng>_addr/_data/_wen                engine RAM requests
//   o_s_addr/o_s_wdata/o_s_wen             S RAM port
//   o_phase                                0 idle/done, 1 init, 2 ksa, 3 prga
//   o_busy/o_done/o_error                  status
// ---------------------------------------------------------------------------
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  output logic              o_init_start,
  output logic              o_ksa_start,
  output logic              o_prga_start,
  input  logic              i_init_finish,
  input  logic              i_ksa_finish,
  input  logic              i_prga_finish,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic [ADDR_W-1:0] i_ksa_addr,
  input  logic [ADDR_W-1:0] i_prga_addr,
  input  logic [DATA_W-1:0] i_init_data,
  input  logic [DATA_W-1:0] i_ksa_data,
  input  logic [DATA_W-1:0] i_prga_data,
  input  logic              i_init_wen,
  input  logic              i_ksa_wen,
  input  logic              i_prga_wen,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic              o_s_wen,
  output logic [1:0]        o_phase,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  rc4_seq_state_t r_state;
  rc4_seq_state_t w_state_next;
  rc4_owner_t     r_owner;
  rc4_owner_t     w_owner_next;
  logic           w_timeout;

`ifdef RC4_PHASE_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_run;

  assign w_wd_clear = (r_state == ST_INIT_GO) || (r_state == ST_KSA_GO) ||
                      (r_state == ST_PRGA_GO);
  assign w_wd_run   = (r_state == ST_INIT_RUN) || (r_state == ST_KSA_RUN) ||
                      (r_state == ST_PRGA_RUN);

  rc4_phase_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_wd_clear),
    .i_run     (w_wd_run),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // State and owner registers. The async reset clears the owner, so the
  // combinational mux drops s_wen in the same cycle reset is asserted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWNER_NONE;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
    end
  end

  // Next-state logic. Finish inputs are only looked at in the matching RUN
  // state, which masks stale levels during GO and finishes from other engines.
  // Finish is tested before the timeout so it wins a same-cycle tie.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) w_state_next = ST_INIT_GO;
      end
      ST_INIT_GO:  w_state_next = ST_INIT_RUN;
      ST_INIT_RUN: begin
        if (i_init_finish) w_state_next = ST_KSA_GO;
`ifdef RC4_PHASE_TIMEOUT_EN
        else if (w_timeout) w_state_next = ST_ERR;
`endif
      end
      ST_KSA_GO:   w_state_next = ST_KSA_RUN;
      ST_KSA_RUN: begin
        if (i_ksa_finish) w_state_next = ST_PRGA_GO;
`ifdef RC4_PHASE_TIMEOUT_EN
        else if (w_timeout) w_state_next = ST_ERR;
`endif
      end
      ST_PRGA_GO:  w_state_next = ST_PRGA_RUN;
      ST_PRGA_RUN: begin
        if (i_prga_finish) w_state_next = ST_DONE;
`ifdef RC4_PHASE_TIMEOUT_EN
        else if (w_timeout) w_state_next = ST_ERR;
`endif
      end
`ifdef RC4_PHASE_TIMEOUT_EN
      ST_ERR: begin
        if (i_start) w_state_next = ST_INIT_GO;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
    w_owner_next = owner_of(w_state_next);
  end

  // Moore status outputs decoded from the state register.
  always_comb begin
    o_init_start = 1'b0;
    o_ksa_start  = 1'b0;
    o_prga_start = 1'b0;
    o_phase      = PHASE_IDLE;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    case (r_state)
      ST_INIT_GO: begin
        o_init_start = 1'b1;
        o_phase      = PHASE_INIT;
        o_busy       = 1'b1;
      end
      ST_INIT_RUN: begin
        o_phase = PHASE_INIT;
        o_busy  = 1'b1;
      end
      ST_KSA_GO: begin
        o_ksa_start = 1'b1;
        o_phase     = PHASE_KSA;
        o_busy      = 1'b1;
      end
      ST_KSA_RUN: begin
        o_phase = PHASE_KSA;
        o_busy  = 1'b1;
      end
      ST_PRGA_GO: begin
        o_prga_start = 1'b1;
        o_phase      = PHASE_PRGA;
        o_busy       = 1'b1;
      end
      ST_PRGA_RUN: begin
        o_phase = PHASE_PRGA;
        o_busy  = 1'b1;
      end
      ST_DONE: o_done = 1'b1;
`ifdef RC4_PHASE_TIMEOUT_EN
      ST_ERR:  o_error = 1'b1;
`endif
      default: ;
    endcase
  end

  // RAM port mux: purely combinational from the owner register, so a
  // non-owner's write enable can never reach the RAM.
  always_comb begin
    o_s_addr  = '0;
    o_s_wdata = '0;
    o_s_wen   = 1'b0;
    case (r_owner)
      OWNER_INIT: begin
        o_s_addr  = i_init_addr;
        o_s_wdata = i_init_data;
        o_s_wen   = i_init_wen;
      end
      OWNER_KSA: begin
        o_s_addr  = i_ksa_addr;
        o_s_wdata = i_ksa_data;
        o_s_wen   = i_ksa_wen;
      end
      OWNER_PRGA: begin
        o_s_addr  = i_prga_addr;
        o_s_wdata = i_prga_data;
        o_s_wen   = i_prga_wen;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rc4_phase_sequencer
//   Directed self-checking bench for rc4_phase_sequencer. Inputs change 2 ns
//   after each rising edge; outputs are checked in the same window.
//   The timeout scenario is compiled only with RC4_PHASE_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rc4_phase_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_start;
  logic       o_init_start, o_ksa_start, o_prga_start;
  logic       i_init_finish, i_ksa_finish, i_prga_finish;
  logic [7:0] i_init_addr, i_ksa_addr, i_prga_addr;
  logic [7:0] i_init_data, i_ksa_data, i_prga_data;
  logic       i_init_wen, i_ksa_wen, i_prga_wen;
  logic [7:0] o_s_addr, o_s_wdata;
  logic       o_s_wen;
  logic [1:0] o_phase;
  logic       o_busy, o_done, o_error;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_init = 0, cnt_ksa = 0, cnt_prga = 0;

  always #5 i_clk = ~i_clk;

  rc4_phase_sequencer #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .o_init_start  (o_init_start),
    .o_ksa_start   (o_ksa_start),
    .o_prga_start  (o_prga_start),
    .i_init_finish (i_init_finish),
    .i_ksa_finish  (i_ksa_finish),
    .i_prga_finish (i_prga_finish),
    .i_init_addr   (i_init_addr),
    .i_ksa_addr    (i_ksa_addr),
    .i_prga_addr   (i_prga_addr),
    .i_init_data   (i_init_data),
    .i_ksa_data    (i_ksa_data),
    .i_prga_data   (i_prga_data),
    .i_init_wen    (i_init_wen),
    .i_ksa_wen     (i_ksa_wen),
    .i_prga_wen    (i_prga_wen),
    .o_s_addr      (o_s_addr),
    .o_s_wdata     (o_s_wdata),
    .o_s_wen       (o_s_wen),
    .o_phase       (o_phase),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  // Count start pulses (cycles each start output is high).
  always @(posedge i_clk) begin
    if (o_init_start) cnt_init <= cnt_init + 1;
    if (o_ksa_start)  cnt_ksa  <= cnt_ksa + 1;
    if (o_prga_start) cnt_prga <= cnt_prga + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
    $display("[TB] check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  initial begin
    i_reset_n = 1'b0; i_start = 1'b0;
    i_init_finish = 1'b0; i_ksa_finish = 1'b0; i_prga_finish = 1'b0;
    i_init_addr = 8'hAA; i_ksa_addr = 8'h00; i_prga_addr = 8'h00;
    i_init_data = 8'hBB; i_ksa_data = 8'h00; i_prga_data = 8'h00;
    i_init_wen = 1'b1; i_ksa_wen = 1'b0; i_prga_wen = 1'b0;

    // Reset state: owner none masks the engine's write request.
    #12;
    chk("rst_starts", {29'd0, o_init_start, o_ksa_start, o_prga_start}, 32'd0);
    chk("rst_ram", {15'd0, o_s_wen, o_s_addr, o_s_wdata}, 32'd0);
    chk("rst_status", {27'd0, o_phase, o_busy, o_done, o_error}, 32'd0);
    tick();
    i_reset_n = 1'b1; i_init_wen = 1'b0;
    tick();
    chk("idle_phase", {30'd0, o_phase}, 32'd0);

    // ---- Run 1: each finish 3 cycles into its RUN ----
    i_start = 1'b1;
    tick();                                   // INIT_GO
    i_start = 1'b0;
    chk("init_go_start", {31'd0, o_init_start}, 32'd1);
    chk("init_go_phase", {30'd0, o_phase}, 32'd1);
    chk("init_go_busy", {31'd0, o_busy}, 32'd1);
    tick();                                   // INIT_RUN c1
    chk("init_run_start", {31'd0, o_init_start}, 32'd0);
    i_init_addr = 8'h2A; i_init_data = 8'h2A; i_init_wen = 1'b1;
    i_ksa_addr = 8'h55; i_ksa_wen = 1'b1;
    #1;
    chk("mux_init_addr", {24'd0, o_s_addr}, 32'h2A);
    chk("mux_init_data", {24'd0, o_s_wdata}, 32'h2A);
    chk("mux_init_wen", {31'd0, o_s_wen}, 32'd1);
    i_init_wen = 1'b0; i_ksa_wen = 1'b0;
    tick();                                   // INIT_RUN c2
    tick();                                   // INIT_RUN c3
    i_init_finish = 1'b1;
    chk("init_run3_phase", {30'd0, o_phase}, 32'd1);
    tick();                                   // KSA_GO
    i_init_finish = 1'b0; i_ksa_addr = 8'h11; i_ksa_data = 8'h22;
    #1;
    chk("ksa_go_start", {31'd0, o_ksa_start}, 32'd1);
    chk("ksa_go_phase", {30'd0, o_phase}, 32'd2);
    chk("ksa_go_owner_addr", {24'd0, o_s_addr}, 32'h11);
    chk("ksa_go_owner_data", {24'd0, o_s_wdata}, 32'h22);
    chk("ksa_go_wen", {31'd0, o_s_wen}, 32'd0);
    tick();                                   // KSA_RUN c1
    chk("ksa_run_start", {31'd0, o_ksa_start}, 32'd0);
    tick();
    tick();                                   // KSA_RUN c3
    i_ksa_finish = 1'b1;
    tick();                                   // PRGA_GO
    i_ksa_finish = 1'b0;
    chk("prga_go_start", {31'd0, o_prga_start}, 32'd1);
    chk("prga_go_phase", {30'd0, o_phase}, 32'd3);
    tick();                                   // PRGA_RUN c1
    i_start = 1'b1; i_prga_wen = 1'b1; i_prga_addr = 8'h7E;
    #1;
    chk("mux_prga_wen", {31'd0, o_s_wen}, 32'd1);
    chk("mux_prga_addr", {24'd0, o_s_addr}, 32'h7E);
    tick();                                   // PRGA_RUN c2, start ignored
    i_start = 1'b0; i_prga_wen = 1'b0;
    chk("start_ignored_phase", {30'd0, o_phase}, 32'd3);
    chk("start_ignored_pulse", {31'd0, o_init_start}, 32'd0);
    tick();                                   // PRGA_RUN c3
    i_prga_finish = 1'b1;
    tick();                                   // DONE
    i_prga_finish = 1'b0;
    chk("done_flag", {31'd0, o_done}, 32'd1);
    chk("done_phase", {30'd0, o_phase}, 32'd0);
    chk("done_busy", {31'd0, o_busy}, 32'd0);
    chk("done_ram_addr", {24'd0, o_s_addr}, 32'd0);
    tick();
    chk("done_hold", {31'd0, o_done}, 32'd1);
    chk("pulse_count_init", cnt_init, 32'd1);
    chk("pulse_count_ksa", cnt_ksa, 32'd1);
    chk("pulse_count_prga", cnt_prga, 32'd1);

    // ---- Stale init_finish held from previous run ----
    i_init_finish = 1'b1; i_start = 1'b1;
    tick();                                   // INIT_GO
    i_start = 1'b0;
    chk("stale_go_start", {31'd0, o_init_start}, 32'd1);
    chk("stale_go_done", {31'd0, o_done}, 32'd0);
    tick();                                   // INIT_RUN (finish masked in GO)
    chk("stale_run_phase", {30'd0, o_phase}, 32'd1);
    chk("stale_run_noksa", {31'd0, o_ksa_start}, 32'd0);
    tick();                                   // KSA_GO
    i_init_finish = 1'b0;
    chk("stale_ksa_go", {31'd0, o_ksa_start}, 32'd1);
    tick();                                   // KSA_RUN
    i_prga_finish = 1'b1; i_init_finish = 1'b1;
    tick();                                   // still KSA_RUN
    chk("nonowner_fin_phase", {30'd0, o_phase}, 32'd2);
    chk("nonowner_fin_pulse", {31'd0, o_prga_start}, 32'd0);
    i_prga_finish = 1'b0; i_init_finish = 1'b0;

    // ---- Async reset during KSA_RUN with ksa_wen=1 ----
    i_ksa_wen = 1'b1; i_ksa_addr = 8'h33;
    #1;
    chk("pre_rst_wen", {31'd0, o_s_wen}, 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk("async_rst_wen", {31'd0, o_s_wen}, 32'd0);
    chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("async_rst_addr", {24'd0, o_s_addr}, 32'd0);
    tick();
    i_reset_n = 1'b1; i_ksa_wen = 1'b0;
    tick();
    chk("post_rst_status", {27'd0, o_phase, o_busy, o_done, o_error}, 32'd0);

    // ---- Minimum run with instant finishes: done exactly 7 cycles later ----
    i_init_finish = 1'b1; i_ksa_finish = 1'b1; i_prga_finish = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k < 7; k++) begin
      chk($sformatf("minrun_c%0d_notdone", k), {31'd0, o_done}, 32'd0);
      tick();
    end
    chk("minrun_c7_done", {31'd0, o_done}, 32'd1);
    chk("no_error_default", {31'd0, o_error}, 32'd0);
    i_init_finish = 1'b0; i_ksa_finish = 1'b0; i_prga_finish = 1'b0;

`ifdef RC4_PHASE_TIMEOUT_EN
    // ---- KSA never finishes: ERR after 16 cycles of KSA_RUN ----
    i_start = 1'b1;
    tick();                                   // INIT_GO
    i_start = 1'b0; i_init_finish = 1'b1;
    tick();                                   // INIT_RUN
    tick();                                   // KSA_GO
    i_init_finish = 1'b0;
    tick();                                   // KSA_RUN c1
    i_ksa_wen = 1'b1;
    for (int k = 2; k <= 16; k++) tick();     // KSA_RUN c16
    chk("to_c16_phase", {30'd0, o_phase}, 32'd2);
    chk("to_c16_error", {31'd0, o_error}, 32'd0);
    tick();                                   // ERR
    chk("to_err_flag", {31'd0, o_error}, 32'd1);
    chk("to_err_wen", {31'd0, o_s_wen}, 32'd0);
    chk("to_err_busy", {31'd0, o_busy}, 32'd0);
    i_ksa_wen = 1'b0; i_start = 1'b1;
    tick();                                   // INIT_GO
    i_start = 1'b0;
    chk("err_restart_start", {31'd0, o_init_start}, 32'd1);
    chk("err_restart_error", {31'd0, o_error}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
